// File: rtl/tv_pkg.sv
// tv_pkg: state encoding and golden-word packing shared by the test-vector recorder files.
// Latency: none (types, constants and a packing macro only).
// Backpressure: none.
// Ports: none.
`ifndef TV_PKG_SV
`define TV_PKG_SV
// Golden word layout: DUT stimulus in the upper bits, DUT response in the lower bits,
// i.e. the same {inputs, expected} order the replay benches read from .tv files.
`define TV_PACK(in_v, out_v) {(in_v), (out_v)}

package tv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } tv_state_t;

endpackage
`endif

// File: rtl/tv_settle_cnt.sv
// tv_settle_cnt: loadable down-counter with zero flag, paces how long dut_in is held before sampling.
// Latency: load/decrement take effect at the next posedge; zero is a decode of the current count.
// Backpressure: none; the parent holds it loaded while it is not settling.
// Ports: clk, reset (sync, active-low), load/load_val (takes priority), dec (stops at 0), zero.
module tv_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tv_recorder.sv
// tv_recorder: enumerates every IN_W-bit input into a DUT, samples the settled response and writes
//   the golden word {dut_in, dut_out} at address = input value, for 0 .. 2**IN_W-1.
// Latency: after start, vector k is offered at cycle (k+1)*(SETTLE+1) with wr_ready held high;
//   done pulses the cycle after the last accepted write.
// Backpressure: while wr_ready is low, wr_valid/wr_addr/wr_data/dut_in hold; only abort or reset
//   can drop an unaccepted write.
// Ports: clk, reset (sync, active-low); start/abort controls; dut_in -> DUT, dut_out <- DUT;
//   wr_valid/wr_ready/wr_addr/wr_data memory write port; busy, done pulse, count of last full run.
module tv_recorder
  import tv_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int ADDR_W = 10,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [IN_W+OUT_W-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       count
);

  localparam int              CW          = $clog2(SETTLE + 1);
  localparam logic [IN_W:0]   LAST_VEC    = (IN_W + 1)'((1 << IN_W) - 1);
  localparam logic [ADDR_W:0] NUM_VEC     = (ADDR_W + 1)'(1 << IN_W);
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);

  if (IN_W > ADDR_W) begin : g_chk_addr
    $error("tv_recorder: IN_W must not exceed ADDR_W");
  end
  if (SETTLE < 1) begin : g_chk_settle
    $error("tv_recorder: SETTLE must be at least 1");
  end

  tv_state_t     state;
  // One bit wider than dut_in so the terminal compare never relies on wrap-around.
  logic [IN_W:0] vec;
  logic [IN_W:0] vec_inc;
  logic          settle_load;
  logic          settle_dec;
  logic          settle_zero;

  assign vec_inc = vec + (IN_W + 1)'(1);

  // Counter sits at SETTLE-1 whenever we are not settling, so every entry into
  // ST_SETTLE starts a fresh hold window without an explicit reload pulse.
  assign settle_load = (state != ST_SETTLE);
  assign settle_dec  = (state == ST_SETTLE);

  tv_settle_cnt #(
    .W(CW)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .dec      (settle_dec),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      vec      <= '0;
      dut_in   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec    <= '0;
            dut_in <= '0;
            busy   <= 1'b1;
            state  <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            dut_in <= '0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (settle_zero) begin
            // Only this edge samples dut_out; earlier glitches never reach the word.
            wr_data  <= `TV_PACK(vec[IN_W-1:0], dut_out);
            wr_addr  <= ADDR_W'(vec[IN_W-1:0]);
            wr_valid <= 1'b1;
            state    <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          // Abort wins over a simultaneous handshake; the memory is expected to
          // discard a write whose valid drops before acceptance.
          if (abort) begin
            wr_valid <= 1'b0;
            dut_in   <= '0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (wr_ready) begin
            wr_valid <= 1'b0;
            if (vec == LAST_VEC) begin
              dut_in <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              count  <= NUM_VEC;
              state  <= ST_DONE;
            end else begin
              vec    <= vec_inc;
              dut_in <= vec_inc[IN_W-1:0];
              state  <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          // Single-cycle state that carries the done pulse; start is not looked at here.
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
